// File: rtl/tone_seq_pkg.sv
// Shared types for the tone sequencer: FSM states, table entry layout and
// the phase index value that marks the end of a waveform period.
package tone_seq_pkg;

    // Entry period width; the sequencer's PERIOD_W parameter must match it.
    localparam int TONE_PERIOD_W = 16;
    localparam logic [9:0] PHASE_MAX = 10'd1023;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        RUN
    } tone_state_e;

    typedef struct packed {
        logic [31:0]              step;
        logic [TONE_PERIOD_W-1:0] periods;
    } tone_entry_t;

endpackage

// File: rtl/tone_sequencer_if.sv
// Host-side bus of the tone sequencer: table programming, sequence control
// and status.
interface tone_sequencer_if #(
    parameter int ADDR_W   = 4,
    parameter int PERIOD_W = 16
);
    logic                cfg_we;
    logic [ADDR_W-1:0]   cfg_addr;
    logic [31:0]         cfg_step;
    logic [PERIOD_W-1:0] cfg_periods;
    logic [ADDR_W-1:0]   cfg_last;
    logic                loop_en;
    logic                start;
    logic                stop;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   tone_idx;

    modport master (
        output cfg_we, cfg_addr, cfg_step, cfg_periods, cfg_last,
        output loop_en, start, stop,
        input  busy, done, tone_idx
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_step, cfg_periods, cfg_last,
        input  loop_en, start, stop,
        output busy, done, tone_idx
    );
endinterface

// File: rtl/tone_table.sv
// Tone table: NUM_TONES entries written synchronously by the host and read
// combinationally on two ports (current entry and entry being entered).
module tone_table
    import tone_seq_pkg::*;
#(
    parameter int NUM_TONES = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  tone_entry_t       wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output tone_entry_t       rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output tone_entry_t       rd_data_b
);

    tone_entry_t mem [NUM_TONES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/tone_sequencer.sv
// Steps through the tone table, driving the accumulator phase step and
// holding the accumulator cleared between tones; counts waveform wraps.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int NUM_TONES  = 16,
    parameter int ADDR_W     = 4,
    parameter int PERIOD_W   = TONE_PERIOD_W,
    parameter int GAP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    tone_sequencer_if.slave  host,
    input  logic [9:0]       phase_in,
    output logic [31:0]      phase_step,
    output logic             acc_clr_n
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    function automatic logic [ADDR_W-1:0] clamp_last(input logic [ADDR_W-1:0] last);
        if (32'(last) > 32'(NUM_TONES - 1)) begin
            return ADDR_W'(NUM_TONES - 1);
        end
        return last;
    endfunction

    tone_state_e         state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
    logic [9:0]          phase_p1;
    logic                done_d;
    logic                advance;
    logic                wrap;
    logic                wr_en;
    logic [31:0]         step_nxt;
    tone_entry_t         wr_entry, cur, nxt;

    assign wr_en    = host.cfg_we && (state_q == IDLE);
    assign wr_entry = '{step: host.cfg_step, periods: host.cfg_periods};
    assign wrap     = (phase_p1 == PHASE_MAX) && (phase_in == 10'd0);

    tone_table #(
        .NUM_TONES (NUM_TONES),
        .ADDR_W    (ADDR_W)
    ) u_table (
        .clk       (clk),
        .we        (wr_en),
        .wr_addr   (host.cfg_addr),
        .wr_data   (wr_entry),
        .rd_addr_a (idx_q),
        .rd_data_a (cur),
        .rd_addr_b (idx_d),
        .rd_data_b (nxt)
    );

    // A write landing on the same edge as start must already show in the first GAP cycle.
    assign step_nxt = (wr_en && (host.cfg_addr == idx_d)) ? host.cfg_step : nxt.step;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        last_d       = last_q;
        gap_cnt_d    = gap_cnt_q;
        period_cnt_d = period_cnt_q;
        done_d       = 1'b0;
        advance      = 1'b0;
        case (state_q)
            IDLE: begin
                if (host.start) begin
                    last_d    = clamp_last(host.cfg_last);
                    idx_d     = '0;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (cur.periods == '0) begin
                        advance = 1'b1;
                    end else begin
                        period_cnt_d = '0;
                        state_d      = RUN;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            RUN: begin
                if (wrap) begin
                    if (period_cnt_q == cur.periods - PERIOD_W'(1)) begin
                        advance = 1'b1;
                    end else begin
                        period_cnt_d = period_cnt_q + PERIOD_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (advance) begin
            gap_cnt_d = '0;
            if (idx_q != last_q) begin
                idx_d   = idx_q + ADDR_W'(1);
                state_d = GAP;
            end else if (host.loop_en) begin
                idx_d   = '0;
                state_d = GAP;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
        if (host.stop) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b0;
        end
    end

    // Registered outputs follow the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            last_q        <= '0;
            gap_cnt_q     <= '0;
            period_cnt_q  <= '0;
            phase_p1      <= '0;
            phase_step    <= '0;
            acc_clr_n     <= 1'b0;
            host.busy     <= 1'b0;
            host.done     <= 1'b0;
            host.tone_idx <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            last_q        <= last_d;
            gap_cnt_q     <= gap_cnt_d;
            period_cnt_q  <= period_cnt_d;
            phase_p1      <= phase_in;
            phase_step    <= (state_d == IDLE) ? 32'd0 : step_nxt;
            acc_clr_n     <= (state_d == RUN);
            host.busy     <= (state_d != IDLE);
            host.done     <= done_d;
            host.tone_idx <= idx_d;
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer with a prescaled phase accumulator: the phase index
// advances once every step+1 cycles, so one waveform period is 1024*(step+1) cycles.
module tb_tone_sequencer;
    import tone_seq_pkg::*;

    localparam int NUM_TONES  = 16;
    localparam int ADDR_W     = 4;
    localparam int PERIOD_W   = 16;
    localparam int GAP_CYCLES = 4;
    localparam int EW         = 70;
    localparam logic [1:0] K_GAP  = 2'd0;
    localparam logic [1:0] K_RUN  = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    typedef struct packed {
        logic [1:0]        kind;
        logic [ADDR_W-1:0] idx;
        logic [31:0]       step;
        logic [31:0]       len;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  phase;
    logic [31:0] div;
    logic [31:0] phase_step;
    logic        acc_clr_n;

    int checks = 0;
    int passed = 0;

    ev_t exp_q[$];
    ev_t obs_q[$];
    bit                seg_open = 1'b0;
    logic              seg_run;
    logic [ADDR_W-1:0] seg_idx;
    logic [31:0]       seg_step;
    int                seg_len;

    tone_sequencer_if #(.ADDR_W(ADDR_W), .PERIOD_W(PERIOD_W)) host ();

    tone_sequencer #(
        .NUM_TONES  (NUM_TONES),
        .ADDR_W     (ADDR_W),
        .PERIOD_W   (PERIOD_W),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host       (host),
        .phase_in   (phase),
        .phase_step (phase_step),
        .acc_clr_n  (acc_clr_n)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge acc_clr_n) begin
        if (!acc_clr_n) begin
            phase <= '0;
            div   <= '0;
        end else if (div == phase_step) begin
            div   <= '0;
            phase <= phase + 10'd1;
        end else begin
            div <= div + 32'd1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One cycle; the monitor splits busy time into GAP/RUN segments per tone index.
    task automatic tick();
        @(negedge clk);
        if (seg_open && (host.busy !== 1'b1 || acc_clr_n !== seg_run || host.tone_idx !== seg_idx)) begin
            obs_q.push_back(ev_t'{seg_run ? K_RUN : K_GAP, seg_idx, seg_step, 32'(seg_len)});
            seg_open = 1'b0;
        end
        if (host.busy === 1'b1 && !seg_open) begin
            seg_open = 1'b1;
            seg_run  = acc_clr_n;
            seg_idx  = host.tone_idx;
            seg_step = phase_step;
            seg_len  = 0;
        end
        if (seg_open) seg_len++;
        if (host.done === 1'b1) obs_q.push_back(ev_t'{K_DONE, ADDR_W'(0), 32'd0, 32'd0});
    endtask

    task automatic push_exp(input logic [1:0] k, input int idx, input int step, input int len);
        exp_q.push_back(ev_t'{k, ADDR_W'(idx), 32'(step), 32'(len)});
    endtask

    function automatic int run_len(input int s, input int p);
        return 1024 * (s + 1) * p + 1;
    endfunction

    task automatic push_tone(input int idx, input int s, input int p);
        push_exp(K_GAP, idx, s, GAP_CYCLES);
        if (p != 0) push_exp(K_RUN, idx, s, run_len(s, p));
    endtask

    task automatic flush_obs();
        obs_q.delete();
        seg_open = 1'b0;
    endtask

    task automatic check_events(input string tag);
        ev_t e;
        ev_t o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                chk({tag, " missing"}, EW'(0), EW'(e));
            end else begin
                o = obs_q.pop_front();
                chk(tag, EW'(o), EW'(e));
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            chk({tag, " extra"}, EW'(o), EW'(0));
        end
    endtask

    task automatic cfg_write(input int addr, input int step, input int periods);
        host.cfg_addr    = ADDR_W'(addr);
        host.cfg_step    = 32'(step);
        host.cfg_periods = PERIOD_W'(periods);
        host.cfg_we      = 1'b1;
        tick();
        host.cfg_we      = 1'b0;
    endtask

    task automatic start_seq(input int last);
        host.cfg_last = ADDR_W'(last);
        host.start    = 1'b1;
        tick();
        host.start    = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (host.busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        if (host.busy !== 1'b0) chk({tag, " idle timeout"}, EW'(host.busy), EW'(0));
    endtask

    task automatic wait_run(input int idx, input int budget, input string tag);
        int n = 0;
        while (!(host.busy === 1'b1 && acc_clr_n === 1'b1 && host.tone_idx === ADDR_W'(idx)) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({tag, " run timeout"}, EW'(acc_clr_n), EW'(1));
    endtask

    initial begin
        host.cfg_we = 1'b0; host.cfg_addr = '0; host.cfg_step = '0; host.cfg_periods = '0;
        host.cfg_last = '0; host.loop_en = 1'b0; host.start = 1'b0; host.stop = 1'b0;

        // Reset values
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst phase_step", EW'(phase_step), EW'(0));
        chk("rst acc_clr_n", EW'(acc_clr_n), EW'(0));
        chk("rst busy", EW'(host.busy), EW'(0));
        chk("rst done", EW'(host.done), EW'(0));
        chk("rst tone_idx", EW'(host.tone_idx), EW'(0));

        // Single tone: step 0, two periods
        cfg_write(0, 0, 2);
        push_tone(0, 0, 2);
        push_exp(K_DONE, 0, 0, 0);
        start_seq(0);
        wait_idle(20000, "single");
        tick();
        check_events("single");
        chk("single busy after", EW'(host.busy), EW'(0));

        // Three entries with the middle one skipped
        cfg_write(0, 1, 1);
        cfg_write(1, 0, 0);
        cfg_write(2, 2, 1);
        push_tone(0, 1, 1);
        push_tone(1, 0, 0);
        push_tone(2, 2, 1);
        push_exp(K_DONE, 0, 0, 0);
        start_seq(2);
        wait_idle(20000, "three");
        check_events("three");

        // Looping over two entries, loop_en dropped during the second pass of entry 1
        cfg_write(0, 0, 1);
        cfg_write(1, 1, 1);
        host.loop_en = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            push_tone(0, 0, 1);
            push_tone(1, 1, 1);
        end
        push_exp(K_DONE, 0, 0, 0);
        start_seq(1);
        wait_run(1, 10000, "loop a");
        wait_run(0, 10000, "loop b");
        wait_run(1, 10000, "loop c");
        host.loop_en = 1'b0;
        wait_idle(10000, "loop");
        check_events("loop");

        // Asynchronous reset in the middle of entry 1
        host.loop_en = 1'b1;
        start_seq(1);
        wait_run(1, 10000, "midrst");
        repeat (20) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst phase_step", EW'(phase_step), EW'(0));
        chk("midrst acc_clr_n", EW'(acc_clr_n), EW'(0));
        chk("midrst busy", EW'(host.busy), EW'(0));
        chk("midrst tone_idx", EW'(host.tone_idx), EW'(0));
        chk("midrst acc phase", EW'(phase), EW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        flush_obs();
        host.loop_en = 1'b0;
        push_tone(0, 0, 1);
        push_tone(1, 1, 1);
        push_exp(K_DONE, 0, 0, 0);
        start_seq(1);
        wait_idle(10000, "after rst");
        check_events("after rst");

        // Abort in RUN, with an ignored table write during the tone
        cfg_write(0, 0, 2);
        start_seq(0);
        wait_run(0, 100, "abort");
        repeat (10) tick();
        cfg_write(0, 5, 7);
        repeat (10) tick();
        host.stop = 1'b1;
        tick();
        host.stop = 1'b0;
        chk("abort busy", EW'(host.busy), EW'(0));
        chk("abort acc_clr_n", EW'(acc_clr_n), EW'(0));
        chk("abort phase_step", EW'(phase_step), EW'(0));
        chk("abort done", EW'(host.done), EW'(0));
        chk("abort acc phase", EW'(phase), EW'(0));
        tick();
        chk("abort done later", EW'(host.done), EW'(0));
        flush_obs();
        push_tone(0, 0, 2);
        push_exp(K_DONE, 0, 0, 0);
        start_seq(0);
        wait_idle(20000, "readback");
        check_events("readback");

        // start and stop together in IDLE
        host.start = 1'b1;
        host.stop  = 1'b1;
        tick();
        host.start = 1'b0;
        host.stop  = 1'b0;
        chk("startstop busy", EW'(host.busy), EW'(0));
        chk("startstop acc_clr_n", EW'(acc_clr_n), EW'(0));
        tick();
        chk("startstop busy later", EW'(host.busy), EW'(0));
        check_events("startstop");

        // stop on the cycle the final wrap is seen
        cfg_write(0, 0, 1);
        start_seq(0);
        wait_run(0, 100, "stopwrap");
        repeat (1024) tick();
        chk("stopwrap phase at wrap", EW'(phase), EW'(0));
        chk("stopwrap busy at wrap", EW'(host.busy), EW'(1));
        host.stop = 1'b1;
        tick();
        host.stop = 1'b0;
        chk("stopwrap done", EW'(host.done), EW'(0));
        chk("stopwrap busy", EW'(host.busy), EW'(0));
        tick();
        chk("stopwrap done later", EW'(host.done), EW'(0));
        flush_obs();

        // Write and start in the same IDLE cycle: the new entry 0 is played
        host.cfg_addr    = '0;
        host.cfg_step    = 32'd1;
        host.cfg_periods = PERIOD_W'(1);
        host.cfg_we      = 1'b1;
        push_tone(0, 1, 1);
        push_exp(K_DONE, 0, 0, 0);
        start_seq(0);
        host.cfg_we      = 1'b0;
        wait_idle(20000, "wr+start");
        check_events("wr+start");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
